axis_sync_fifo: RTL

AXIS_SYNC_FIFO -- requirements
Module: axis_sync_fifo

---
 rtl/axis_sync_fifo.sv | 118 +++++++++++
 1 files changed

// File: rtl/axis_sync_fifo.sv
// AXI-Stream synchronous FIFO with first-word-fall-through output, fill/packet
// counters, registered almost flags and an optional store-and-forward packet mode.
module axis_sync_fifo #(
    parameter int unsigned DATA_WIDTH    = 8,
    parameter int unsigned FIFO_DEPTH    = 16,
    parameter int unsigned AFULL_THRESH  = FIFO_DEPTH - 2,
    parameter int unsigned AEMPTY_THRESH = 2,
    parameter int unsigned PACKET_MODE   = 0
) (
    input  logic                              clk,
    input  logic                              arstn,
    input  logic [DATA_WIDTH-1:0]             s_axis_tdata,
    input  logic                              s_axis_tlast,
    input  logic                              s_axis_tvalid,
    output logic                              s_axis_tready,
    output logic [DATA_WIDTH-1:0]             m_axis_tdata,
    output logic                              m_axis_tlast,
    output logic                              m_axis_tvalid,
    input  logic                              m_axis_tready,
    output logic [$clog2(FIFO_DEPTH):0]       fill_count,
    output logic [$clog2(FIFO_DEPTH):0]       pkt_count,
    output logic                              almost_full,
    output logic                              almost_empty
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [DATA_WIDTH:0] mem [FIFO_DEPTH];

    logic [CW-1:0]       wr_ptr;
    logic [CW-1:0]       rd_ptr;
    logic [CW-1:0]       wr_ptr_next;
    logic [CW-1:0]       rd_ptr_next;
    logic [CW-1:0]       fill_next;
    logic [CW-1:0]       pkt_next;
    logic                wr_en;
    logic                rd_en;
    logic                wr_last;
    logic                rd_last;
    logic                full_next;
    logic                empty_next;
    logic                tvalid_next;
    logic [DATA_WIDTH:0] head_next;

    // Next-state computation for pointers, counters and the registered head word
    always_comb begin
        wr_en       = s_axis_tvalid && s_axis_tready;
        rd_en       = m_axis_tvalid && m_axis_tready;
        wr_last     = wr_en && s_axis_tlast;
        rd_last     = rd_en && m_axis_tlast;
        wr_ptr_next = wr_ptr + CW'(wr_en);
        rd_ptr_next = rd_ptr + CW'(rd_en);

        fill_next = fill_count;
        if (wr_en && !rd_en) begin
            fill_next = fill_count + CW'(1);
        end else if (rd_en && !wr_en) begin
            fill_next = fill_count - CW'(1);
        end

        pkt_next = pkt_count;
        if (wr_last && !rd_last) begin
            pkt_next = pkt_count + CW'(1);
        end else if (rd_last && !wr_last) begin
            pkt_next = pkt_count - CW'(1);
        end

        full_next  = (wr_ptr_next ^ rd_ptr_next) == {1'b1, {AW{1'b0}}};
        empty_next = (wr_ptr_next == rd_ptr_next);

        // Full clause lets an oversize packet drain instead of deadlocking
        if (PACKET_MODE != 0) begin
            tvalid_next = (pkt_next != '0) || full_next;
        end else begin
            tvalid_next = !empty_next;
        end

        // A write landing in the new head slot can only happen into an empty FIFO
        if (wr_en && (wr_ptr[AW-1:0] == rd_ptr_next[AW-1:0])) begin
            head_next = {s_axis_tlast, s_axis_tdata};
        end else begin
            head_next = mem[rd_ptr_next[AW-1:0]];
        end
    end

    // Control state with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!arstn) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            fill_count    <= '0;
            pkt_count     <= '0;
            s_axis_tready <= 1'b1;
            m_axis_tvalid <= 1'b0;
            almost_full   <= 1'b0;
            almost_empty  <= 1'b1;
        end else begin
            wr_ptr        <= wr_ptr_next;
            rd_ptr        <= rd_ptr_next;
            fill_count    <= fill_next;
            pkt_count     <= pkt_next;
            s_axis_tready <= !full_next;
            m_axis_tvalid <= tvalid_next;
            almost_full   <= (fill_next >= CW'(AFULL_THRESH));
            almost_empty  <= (fill_next <= CW'(AEMPTY_THRESH));
        end
    end

    // Storage and head register are not reset
    always_ff @(posedge clk) begin
        if (arstn && wr_en) begin
            mem[wr_ptr[AW-1:0]] <= {s_axis_tlast, s_axis_tdata};
        end
        {m_axis_tlast, m_axis_tdata} <= head_next;
    end

endmodule
